// File: rtl/rca_16bit.sv
// Registered ripple-carry adder built from a generate chain of one-bit full adders.
// Optional two-stage split of the chain at WIDTH/2 is selected by the RCA_PIPE_EN macro.

module rca_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module rca_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    // Valid semantics: in_valid qualifies a/b/cin at the sampling edge; out_valid is a
    // per-cycle flag marking the cycle a new result appears. There is no ready, so the
    // producer never stalls and every accepted operand set yields exactly one result.

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] w_fa_a;
    logic [WIDTH-1:0] w_fa_b;
    logic [WIDTH-1:0] w_ci;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_co;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            rca_full_adder u_fa (
                .i_a (w_fa_a[gi]),
                .i_b (w_fa_b[gi]),
                .i_c (w_ci[gi]),
                .o_s (w_s[gi]),
                .o_c (w_co[gi])
            );
        end
    endgenerate

`ifdef RCA_PIPE_EN
    logic [HALF-1:0]       r_sum_lo;
    logic                  r_c_mid;
    logic [WIDTH-HALF-1:0] r_a_hi;
    logic [WIDTH-HALF-1:0] r_b_hi;
    logic                  r_v1;

    // Low bits ripple from the live operands; high bits ripple from the stage-1 copies.
    assign w_fa_a = {r_a_hi, a[HALF-1:0]};
    assign w_fa_b = {r_b_hi, b[HALF-1:0]};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
            if (gi == 0) begin : g_lsb
                assign w_ci[gi] = cin;
            end else if (gi == HALF) begin : g_split
                assign w_ci[gi] = r_c_mid;
            end else begin : g_link
                assign w_ci[gi] = w_co[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_lo <= '0;
            r_c_mid  <= 1'b0;
            r_a_hi   <= '0;
            r_b_hi   <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sum_lo <= w_s[HALF-1:0];
                r_c_mid  <= w_co[HALF-1];
                r_a_hi   <= a[WIDTH-1:HALF];
                r_b_hi   <= b[WIDTH-1:HALF];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_sum  <= {w_s[WIDTH-1:HALF], r_sum_lo};
                r_cout <= w_co[WIDTH-1];
                r_ovf  <= w_co[WIDTH-1] ^ w_ci[WIDTH-1];
            end
        end
    end
`else
    assign w_fa_a = a;
    assign w_fa_b = b;
    assign w_ci   = {w_co[WIDTH-2:0], cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_co[WIDTH-1];
                r_ovf  <= w_co[WIDTH-1] ^ w_ci[WIDTH-1];
            end
        end
    end
`endif

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rca_16bit.sv
// Directed and random bench for rca_16bit with an expected-result queue.
// Latency follows the RCA_PIPE_EN build of the design.

module tb_rca_16bit;

`ifdef RCA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        out_valid;

    logic [17:0] exp_q[$];
    logic [17:0] last;
    logic [1:0]  vpipe;
    int          total;
    int          bad;

    rca_16bit #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, then check the output produced after the next edge.
    task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc);
        logic [16:0] full;
        logic [17:0] e;
        logic        ev;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        if (v) begin
            full = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
            e    = {full[16], (ta[15] == tb_v[15]) && (full[15] != ta[15]), full[15:0]};
            exp_q.push_back(e);
        end
        vpipe = {vpipe[0], v};
        @(posedge clk);
        #1;
        ev = vpipe[LAT-1];
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_empty observed=result expected=none");
            end else begin
                e = exp_q.pop_front();
                chk("result", {14'd0, cout, overflow, sum}, {14'd0, e});
                last = e;
            end
        end else begin
            chk("hold", {14'd0, cout, overflow, sum}, {14'd0, last});
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last     = '0;
        vpipe    = '0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Asynchronous reset before any clock edge
        rst = 1'b1;
        #1;
        chk("reset_async", {14'd0, cout, overflow, sum, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h1234, 16'h4321, 1'b0);
        step(1'b0, 16'h1111, 16'h2222, 1'b1);

        // Small unsigned adds
        step(1'b1, 16'h0000, 16'h000F, 1'b0);
        step(1'b1, 16'h0002, 16'h000E, 1'b0);
        step(1'b1, 16'h0002, 16'h0003, 1'b0);
        step(1'b1, 16'h0001, 16'h000F, 1'b0);
        step(1'b1, 16'h0001, 16'h0003, 1'b0);

        // Carry chain and carry-in
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step(1'b1, 16'h0000, 16'h0000, 1'b1);

        // Signed overflow
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0);
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0);

        // Valid gap: result must hold through the idle cycle
        step(1'b1, 16'h0102, 16'h0304, 1'b0);
        step(1'b0, 16'hAAAA, 16'h5555, 1'b1);
        step(1'b1, 16'h0A0B, 16'h0C0D, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Random mix of valid and idle cycles
        for (int i = 0; i < 24; i++) begin
            step(($urandom_range(0, 3) != 0),
                 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
        end

        // Mid-stream reset pulse between edges; in-flight work is dropped
        step(1'b1, 16'h1357, 16'h2468, 1'b0);
        step(1'b1, 16'h4000, 16'h4000, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("reset_mid", {14'd0, cout, overflow, sum, out_valid}, 32'd0);
        exp_q.delete();
        vpipe = '0;
        last  = '0;
        #2;
        rst = 1'b0;
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 16'hC000, 16'h4000, 1'b1);
        step(1'b1, 16'h00FF, 16'h0F01, 1'b0);

        // Drain the pipeline
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rca_16bit.md
Name: rca_16bit

Overview:
- Registered ripple-carry adder: sum = a + b + cin over WIDTH bits (default 16), with carry-out and a signed-overflow flag.
- Built from a structural chain of WIDTH one-bit full adders; carry ripples LSB to MSB within one clock period.
- Results are captured in output registers.
- General-purpose arithmetic leaf cell; a baseline for comparison against the faster adder variants in the same library.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b and cin for capture this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B, unsigned or two's complement.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry out of bit WIDTH-1.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high when sum/cout/overflow hold a result.

Behaviour:
- Full adder for bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = cin.
- Ripple chain is instantiated bit-by-bit (generate loop of a full-adder submodule). The + operator is not used for the datapath.
- Widths:
  - {cout, sum} equals the (WIDTH+1)-bit value a + b + cin exactly.
  - overflow = c[WIDTH] ^ c[WIDTH-1].
- Latency 1 (default build): when in_valid=1 at rising edge N, sum/cout/overflow are updated and out_valid=1 after edge N.
- When in_valid=0 at an edge:
  - out_valid drops to 0.
  - sum/cout/overflow hold their previous values.
- Throughput: one result per cycle. No backpressure and no stall input.
- Reset (asynchronous on rst high): sum=0, cout=0, overflow=0, out_valid=0, immediately and independent of clk.
- Reset is held while rst=1. The first capture is at the first rising edge with rst=0 and in_valid=1.
- Reset mid-operation: any in-flight result is discarded, including the pipeline stage when that option is built. No result for it is ever presented.
- Boundary: all-ones + all-ones + cin=1 gives sum=all-ones, cout=1. No saturation; results wrap modulo 2^WIDTH.

Optional Feature:
- Macro: RCA_PIPE_EN.
- Defined:
  - Chain is split at bit WIDTH/2 (integer division).
  - Low half sum bits, the carry into bit WIDTH/2, the upper operand halves and a valid bit are registered in stage 1. All of these stage-1 registers reset to 0.
  - Stage 2 completes the upper ripple and output registers.
  - Latency 2 cycles, throughput 1 per cycle. out_valid follows in_valid delayed by 2 cycles.
  - overflow and cout are computed from the upper-half chain.
- Not defined: single-stage, latency 1, as described above.
- Results are bit-identical in both builds; only timing differs.

Test Plan:
- Reset: assert rst with clk idle → sum=0x0000, cout=0, overflow=0, out_valid=0 immediately. Release; no out_valid until in_valid is driven.
- Small unsigned adds, cin=0, one per cycle with in_valid=1:
  - 0x0000+0x000F → 0x000F
  - 0x0002+0x000E → 0x0010
  - 0x0002+0x0003 → 0x0005
  - 0x0001+0x000F → 0x0010
  - 0x0001+0x0003 → 0x0004
  - All with cout=0, overflow=0, each valid 1 cycle later (2 with RCA_PIPE_EN).
- Carry chain and cin:
  - 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, overflow=0.
  - 0xFFFF+0xFFFF, cin=1 → sum=0xFFFF, cout=1.
  - 0x0000+0x0000, cin=1 → 0x0001.
- Signed overflow:
  - 0x7FFF+0x0001 → sum=0x8000, overflow=1, cout=0.
  - 0x8000+0x8000 → sum=0x0000, overflow=1, cout=1.
- Valid handling: in_valid=1,0,1 on consecutive cycles with distinct operands → out_valid pattern 1,0,1 at the required latency; sum holds its value during the 0 cycle.
- Mid-stream reset: drive back-to-back valid inputs, pulse rst between clock edges → outputs zero asynchronously, in-flight results are never presented, and next valid input produces a correct result. Run under both RCA_PIPE_EN builds.
